// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state type and default geometry for mem_ctrl.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        VERIFY = 2'd3
    } state_t;

    localparam int MEM_ADDR_W   = 12;
    localparam int MEM_DATA_W   = 8;
    localparam int MEM_READ_LAT = 2;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: valid/ready initiator for the single-port chip SRAM.
// Define MEM_CTRL_WR_VERIFY_EN to add a read-back check after every write.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int READ_LAT   = MEM_READ_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_err,
    output logic                  cs,
    output logic                  we,
    output logic                  oe,
    output logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_accept;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    // The bus is released whenever we are not in the single write cycle.
    assign data      = (r_state == WRITE && !rst) ? r_wdata : 'z;

`ifdef MEM_CTRL_WR_VERIFY_EN
    logic r_wr_err;
    assign wr_err = r_wr_err;
`else
    assign wr_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wdata   <= '0;
            cs        <= 1'b0;
            we        <= 1'b0;
            oe        <= 1'b0;
            addr      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef MEM_CTRL_WR_VERIFY_EN
            r_wr_err  <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef MEM_CTRL_WR_VERIFY_EN
            r_wr_err  <= 1'b0;
`endif
            case (r_state)
                IDLE: if (w_accept) begin
                    r_wdata <= req_wdata;
                    addr    <= req_addr;
                    cs      <= 1'b1;
                    we      <= req_we;
                    oe      <= !req_we;
                    r_cnt   <= LAT_M1;
                    r_state <= req_we ? WRITE : READ;
                end
                WRITE: begin
`ifdef MEM_CTRL_WR_VERIFY_EN
                    we      <= 1'b0;
                    oe      <= 1'b1;
                    r_cnt   <= LAT_M1;
                    r_state <= VERIFY;
`else
                    cs      <= 1'b0;
                    we      <= 1'b0;
                    r_state <= IDLE;
`endif
                end
                READ: if (r_cnt == 4'd0) begin
                    rsp_rdata <= data;
                    rsp_valid <= 1'b1;
                    cs        <= 1'b0;
                    oe        <= 1'b0;
                    r_state   <= IDLE;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
`ifdef MEM_CTRL_WR_VERIFY_EN
                VERIFY: if (r_cnt == 4'd0) begin
                    r_wr_err <= (data != r_wdata);
                    cs       <= 1'b0;
                    oe       <= 1'b0;
                    r_state  <= IDLE;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
`endif
                default: begin
                    cs      <= 1'b0;
                    we      <= 1'b0;
                    oe      <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
